countdown_tmr: RTL and testbench

COUNTDOWN_TMR -- requirements
Module: COUNTDOWN_TMR

---
 rtl/countdown_tmr_pkg.sv | 37 +++
 rtl/bcd_down_digit.sv | 49 ++++
 rtl/countdown_tmr.sv | 177 +++++++++++++++++
 tb/tb_countdown_tmr.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_tmr_pkg.sv
// countdown_tmr_pkg
//   Definitions shared by the countdown timer and its digit cells:
//   - FSM state encoding (2-bit)
//   - per-digit maximum constants (9 for decimal digits, 5 for tens of
//     seconds/minutes in MM:SS mode)
//   - small helpers for digit maxima, preset clamping and prescaler sizing
package countdown_tmr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } tmr_state_e;

    localparam logic [3:0] DIGIT_MAX_UNITS = 4'd9;
    localparam logic [3:0] DIGIT_MAX_TENS  = 4'd5;

    // Digits 1 and 3 are tens-of-seconds / tens-of-minutes in MM:SS mode.
    function automatic logic [3:0] digit_max(input int idx, input int mmss);
        if (mmss != 0 && (idx == 1 || idx == 3)) begin
            return DIGIT_MAX_TENS;
        end
        return DIGIT_MAX_UNITS;
    endfunction

    function automatic logic [3:0] clamp_digit(input logic [3:0] d,
                                               input logic [3:0] mx);
        return (d > mx) ? mx : d;
    endfunction

    // A divide-by-1 prescaler still needs a 1-bit register to be legal.
    function automatic int psc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit
//   One BCD digit of the countdown register. Loads a value, or decrements
//   by one when a borrow arrives; at 0 it wraps to MAX and passes the
//   borrow on to the next digit.
// Ports:
//   clk_i     clock, rising edge
//   clr_i     synchronous active-high clear
//   ld_i      load strobe (wins over borrow)
//   ld_val_i  value to load
//   bi_i      borrow in (decrement request)
//   q_o       digit value
//   bo_o      borrow out to the next more significant digit
module bcd_down_digit
    import countdown_tmr_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX_UNITS
) (
    input  logic       clk_i,
    input  logic       clr_i,
    input  logic       ld_i,
    input  logic [3:0] ld_val_i,
    input  logic       bi_i,
    output logic [3:0] q_o,
    output logic       bo_o
);

    logic [3:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (ld_i) begin
            q_d = ld_val_i;
        end else if (bi_i) begin
            q_d = (q_q == 4'd0) ? MAX : (q_q - 4'd1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o  = q_q;
    assign bo_o = bi_i & (q_q == 4'd0);

endmodule

// File: rtl/countdown_tmr.sv
// countdown_tmr
//   BCD countdown timer with prescaler, pause/resume and one-cycle alarm.
//   DIGITS BCD digits; MODE_MMSS=1 makes digits [3:0] an MM:SS field.
//   One count tick every TICK_DIV CE-qualified cycles while running.
// Ports:
//   CLK       clock, rising edge
//   CLR       synchronous active-high reset, highest priority
//   CE        clock enable for the prescaler / count only
//   START     start / resume request (one cycle)
//   STOP      pause / abort request (one cycle)
//   LOAD      preset load strobe (one cycle)
//   LOAD_VAL  BCD preset, digit 0 in the LSBs
//   Q         current BCD count (registered)
//   RUN       high while counting
//   DONE      high after expiry
//   ALARM     one-cycle pulse on expiry
module countdown_tmr
    import countdown_tmr_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int MODE_MMSS = 0,
    parameter int TICK_DIV  = 100000000
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  CE,
    input  logic                  START,
    input  logic                  STOP,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  RUN,
    output logic                  DONE,
    output logic                  ALARM
);

    localparam int             QW       = 4 * DIGITS;
    localparam int             PSC_W    = psc_width(TICK_DIV);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);
    localparam logic [PSC_W-1:0] PSC_ONE  = PSC_W'(1);
    localparam logic [QW-1:0]  Q_ONE    = QW'(1);

    tmr_state_e              state_q, state_d;
    logic [PSC_W-1:0]        psc_q, psc_d;
    logic [QW-1:0]           preset_q, preset_d;
    logic                    alarm_q, alarm_d;

    logic [DIGITS-1:0][3:0]  ld_clamped;
    logic [DIGITS-1:0][3:0]  q_dig;
    logic                    q_ld;
    logic [QW-1:0]           q_ld_val;
    logic                    tick_dec;
    logic [DIGITS:0]         borrow;
    logic                    q_nz;
    logic                    q_is_one;
    logic                    unused_borrow;

    // ------------------------------------------------------------------
    // Digit array: clamp on load, ripple-borrow decrement.
    // ------------------------------------------------------------------
    assign borrow[0] = tick_dec;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
        localparam logic [3:0] MX = digit_max(gi, MODE_MMSS);

        assign ld_clamped[gi] = clamp_digit(LOAD_VAL[4*gi +: 4], MX);

        bcd_down_digit #(
            .MAX      (MX)
        ) u_digit (
            .clk_i    (CLK),
            .clr_i    (CLR),
            .ld_i     (q_ld),
            .ld_val_i (q_ld_val[4*gi +: 4]),
            .bi_i     (borrow[gi]),
            .q_o      (q_dig[gi]),
            .bo_o     (borrow[gi+1])
        );
    end

    // The top digit's borrow would only fire on an underflow, which the
    // q_nz guard on tick_dec prevents.
    assign unused_borrow = borrow[DIGITS];

    assign Q        = q_dig;
    assign q_nz     = |Q;
    assign q_is_one = (Q == Q_ONE);

    // ------------------------------------------------------------------
    // Control FSM. Priority: LOAD > STOP > START; a tick coinciding with
    // LOAD or STOP is dropped because those branches never raise it.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        psc_d    = psc_q;
        preset_d = preset_q;
        alarm_d  = 1'b0;
        q_ld     = 1'b0;
        q_ld_val = ld_clamped;
        tick_dec = 1'b0;

        if (LOAD) begin
            preset_d = ld_clamped;
            q_ld     = 1'b1;
            q_ld_val = ld_clamped;
            psc_d    = '0;
            state_d  = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!STOP && START && q_nz) begin
                        psc_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (STOP) begin
                        state_d = ST_PAUSE;
                    end else if (CE) begin
                        if (psc_q == PSC_LAST) begin
                            psc_d    = '0;
                            tick_dec = q_nz;
                            if (q_is_one) begin
                                state_d = ST_DONE;
                                alarm_d = 1'b1;
                            end
                        end else begin
                            psc_d = psc_q + PSC_ONE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (STOP) begin
                        q_ld     = 1'b1;
                        q_ld_val = preset_q;
                        state_d  = ST_IDLE;
                    end else if (START) begin
                        // Prescaler kept so the partial tick carries over.
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (STOP) begin
                        q_ld     = 1'b1;
                        q_ld_val = preset_q;
                        state_d  = ST_IDLE;
                    end else if (START && (|preset_q)) begin
                        q_ld     = 1'b1;
                        q_ld_val = preset_q;
                        psc_d    = '0;
                        state_d  = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q  <= ST_IDLE;
            psc_q    <= '0;
            preset_q <= '0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            psc_q    <= psc_d;
            preset_q <= preset_d;
            alarm_q  <= alarm_d;
        end
    end

    assign RUN   = (state_q == ST_RUN);
    assign DONE  = (state_q == ST_DONE);
    assign ALARM = alarm_q;

endmodule

// File: tb/tb_countdown_tmr.sv
// tb_countdown_tmr
//   Drives a decimal instance and an MM:SS instance with identical inputs
//   and compares both against an integer-valued reference model every
//   cycle, plus fixed expectations for the directed scenarios.
module tb_countdown_tmr;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        clr, ce, start, stop, load;
    logic [15:0] load_val;
    logic [15:0] q_d, q_m;
    logic        run_d, run_m, done_d, done_m, al_d, al_m;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: count held as a plain integer (seconds in MM:SS mode).
    int m_val[2];
    int m_pre[2];
    int m_st[2];   // 0 idle, 1 run, 2 pause, 3 done
    int m_ph[2];
    bit m_al[2];

    always #5 clk = ~clk;

    countdown_tmr #(.DIGITS(4), .MODE_MMSS(0), .TICK_DIV(TD)) u_dec (
        .CLK(clk), .CLR(clr), .CE(ce), .START(start), .STOP(stop),
        .LOAD(load), .LOAD_VAL(load_val),
        .Q(q_d), .RUN(run_d), .DONE(done_d), .ALARM(al_d)
    );

    countdown_tmr #(.DIGITS(4), .MODE_MMSS(1), .TICK_DIV(TD)) u_mmss (
        .CLK(clk), .CLR(clr), .CE(ce), .START(start), .STOP(stop),
        .LOAD(load), .LOAD_VAL(load_val),
        .Q(q_m), .RUN(run_m), .DONE(done_m), .ALARM(al_m)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int radix(input int i, input int mm);
        return (mm != 0 && (i == 1 || i == 3)) ? 6 : 10;
    endfunction

    function automatic int bcd2int(input logic [15:0] v, input int mm);
        int acc = 0;
        int w   = 1;
        for (int i = 0; i < 4; i++) begin
            int d = int'(v[4*i +: 4]);
            if (d > radix(i, mm) - 1) d = radix(i, mm) - 1;
            acc += d * w;
            w   *= radix(i, mm);
        end
        return acc;
    endfunction

    function automatic logic [15:0] int2bcd(input int n, input int mm);
        logic [15:0] r = '0;
        int          x = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % radix(i, mm));
            x           = x / radix(i, mm);
        end
        return r;
    endfunction

    task automatic model_step(input int k);
        m_al[k] = 1'b0;
        if (clr) begin
            m_val[k] = 0; m_pre[k] = 0; m_st[k] = 0; m_ph[k] = 0;
        end else if (load) begin
            m_pre[k] = bcd2int(load_val, k);
            m_val[k] = m_pre[k];
            m_ph[k]  = 0;
            m_st[k]  = 0;
        end else begin
            case (m_st[k])
                0: if (!stop && start && m_val[k] != 0) begin
                       m_st[k] = 1; m_ph[k] = 0;
                   end
                1: if (stop) m_st[k] = 2;
                   else if (ce) begin
                       if (m_ph[k] == TD - 1) begin
                           m_ph[k] = 0;
                           m_val[k]--;
                           if (m_val[k] == 0) begin
                               m_st[k] = 3; m_al[k] = 1'b1;
                           end
                       end else begin
                           m_ph[k]++;
                       end
                   end
                2: if (stop) begin
                       m_val[k] = m_pre[k]; m_st[k] = 0;
                   end else if (start) m_st[k] = 1;
                default: if (stop) begin
                       m_val[k] = m_pre[k]; m_st[k] = 0;
                   end else if (start && m_pre[k] != 0) begin
                       m_val[k] = m_pre[k]; m_ph[k] = 0; m_st[k] = 1;
                   end
            endcase
        end
    endtask

    task automatic compare();
        chk("dec_q",     q_d,    int2bcd(m_val[0], 0));
        chk("dec_run",   run_d,  m_st[0] == 1);
        chk("dec_done",  done_d, m_st[0] == 3);
        chk("dec_alarm", al_d,   m_al[0]);
        chk("mm_q",      q_m,    int2bcd(m_val[1], 1));
        chk("mm_run",    run_m,  m_st[1] == 1);
        chk("mm_done",   done_m, m_st[1] == 3);
        chk("mm_alarm",  al_m,   m_al[1]);
    endtask

    // Inputs change #1 after a rising edge and are sampled at the next one.
    task automatic cyc();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare();
    endtask

    task automatic pulse_load(input logic [15:0] v);
        load_val = v; load = 1'b1; cyc(); load = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    initial begin
        clr = 1'b1; ce = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0;
        load_val = '0;
        for (int k = 0; k < 2; k++) begin
            m_val[k] = 0; m_pre[k] = 0; m_st[k] = 0; m_ph[k] = 0; m_al[k] = 0;
        end
        cyc(); cyc();
        chk("rst_q", q_d, 16'h0000);
        chk("rst_run", run_d, 1'b0);
        chk("rst_done", done_d, 1'b0);
        chk("rst_alarm", al_d, 1'b0);
        clr = 1'b0;

        // Reset mid-run aborts with no alarm.
        pulse_load(16'h0050);
        pulse_start();
        repeat (6) cyc();
        chk("clr_pre_run", run_d, 1'b1);
        clr = 1'b1; cyc(); cyc(); clr = 1'b0;
        chk("clr_q", q_d, 16'h0000);
        chk("clr_run", run_d, 1'b0);
        chk("clr_done", done_d, 1'b0);
        chk("clr_alarm", al_d, 1'b0);

        // Basic countdown from 3 to expiry.
        pulse_load(16'h0003);
        pulse_start();
        repeat (4) cyc();
        chk("cd_q2", q_d, 16'h0002);
        repeat (4) cyc();
        chk("cd_q1", q_d, 16'h0001);
        repeat (3) cyc();
        chk("cd_q1_hold", q_d, 16'h0001);
        cyc();
        chk("cd_q0", q_d, 16'h0000);
        chk("cd_alarm", al_d, 1'b1);
        chk("cd_done", done_d, 1'b1);
        chk("cd_mm_alarm", al_m, 1'b1);
        cyc();
        chk("cd_alarm_once", al_d, 1'b0);
        chk("cd_done_hold", done_d, 1'b1);

        // MM:SS borrow and load clamping.
        pulse_load(16'h0100);
        pulse_start();
        repeat (4) cyc();
        chk("mm_tick", q_m, 16'h0059);
        chk("dec_tick", q_d, 16'h0099);
        pulse_load(16'h0A7C);
        chk("mm_clamp", q_m, 16'h0959);
        chk("dec_clamp", q_d, 16'h0979);

        // Pause preserves the partial tick.
        pulse_load(16'h0005);
        pulse_start();
        cyc(); cyc();
        pulse_stop();
        chk("ps_pause_run", run_d, 1'b0);
        repeat (10) cyc();
        pulse_start();
        chk("ps_resume_q", q_d, 16'h0005);
        cyc();
        chk("ps_q_early", q_d, 16'h0005);
        cyc();
        chk("ps_q_tick", q_d, 16'h0004);

        // LOAD beats START; START with Q=0 is ignored.
        cyc();
        load_val = 16'h0042; load = 1'b1; start = 1'b1; cyc();
        load = 1'b0; start = 1'b0;
        chk("ls_q", q_d, 16'h0042);
        chk("ls_run", run_d, 1'b0);
        pulse_load(16'h0000);
        pulse_start();
        chk("zero_start_run", run_d, 1'b0);

        // CE low freezes counting but not control.
        pulse_load(16'h0007);
        pulse_start();
        ce = 1'b0;
        repeat (20) cyc();
        chk("ce_q", q_d, 16'h0007);
        chk("ce_run", run_d, 1'b1);
        pulse_stop();
        chk("ce_stop_run", run_d, 1'b0);
        chk("ce_stop_q", q_d, 16'h0007);
        pulse_stop();
        ce = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            clr   = ($urandom_range(0, 299) == 0);
            load  = ($urandom_range(0, 24) == 0);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 19) == 0);
            ce    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) begin
                load_val = 16'($urandom);
            end else begin
                load_val = {8'h00, 4'($urandom_range(0, 2)),
                            4'($urandom_range(0, 15))};
            end
            cyc();
        end
        clr = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
